// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared constants for the UART receive path: FSM state
//             encoding, parity type codes, default frame geometry and the
//             3-sample majority helper.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry
    localparam int c_DATA_WIDTH_DEF = 8;
    localparam int c_OVERSAMPLE_DEF = 8;

    // Receiver FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Parity type codes as presented on PAR_TYP
    localparam logic c_PAR_EVEN = 1'b0;
    localparam logic c_PAR_ODD  = 1'b1;

    // Two-of-three vote used to decide each bit
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Brief    : Oversample tick counter for one UART bit period. Captures the
//             line at the three centre ticks, votes, and pulses o_bit_done
//             on the last tick of the bit with the voted value on o_bit_val.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic RX_IN,
    input  logic i_start,
    input  logic i_active,
    output logic o_bit_done,
    output logic o_bit_val
);

    localparam int                c_CNT_W = $clog2(OVERSAMPLE);
    localparam int                c_MID   = OVERSAMPLE / 2;
    localparam logic [c_CNT_W-1:0] c_S0   = c_CNT_W'(c_MID - 1);
    localparam logic [c_CNT_W-1:0] c_S1   = c_CNT_W'(c_MID);
    localparam logic [c_CNT_W-1:0] c_S2   = c_CNT_W'(c_MID + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(OVERSAMPLE - 1);

    logic [c_CNT_W-1:0] r_edge_cnt;
    logic [2:0]         r_samp;

    // Tick counter: the start-detect cycle is tick 0, so the next tick is 1
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_edge_cnt <= '0;
        end else if (i_start) begin
            r_edge_cnt <= c_CNT_W'(1);
        end else if (i_active) begin
            r_edge_cnt <= (r_edge_cnt == c_LAST) ? '0 : r_edge_cnt + 1'b1;
        end else begin
            r_edge_cnt <= '0;
        end
    end

    // Capture the line at the three ticks around the bit centre
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_samp <= '0;
        end else if (i_active) begin
            if (r_edge_cnt == c_S0) r_samp[0] <= RX_IN;
            if (r_edge_cnt == c_S1) r_samp[1] <= RX_IN;
            if (r_edge_cnt == c_S2) r_samp[2] <= RX_IN;
        end
    end

    assign o_bit_done = i_active && (r_edge_cnt == c_LAST);
    assign o_bit_val  = majority3(r_samp[0], r_samp[1], r_samp[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : UART receiver. Detects the start bit, deserialises DATA_WIDTH
//             bits LSB first, checks optional parity and the stop bit, and
//             emits one strobe per frame: DATA_VALID, PAR_ERR or STP_ERR.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int              c_BC_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BC_W-1:0] c_LAST_BIT = c_BC_W'(DATA_WIDTH - 1);

    logic [2:0]            r_state;
    logic [c_BC_W-1:0]     r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_armed;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_err;

    logic w_start;
    logic w_active;
    logic w_bit_done;
    logic w_bit_val;
    logic w_par_exp;

    // A start edge is only accepted in IDLE once the line has been seen high
    // after a framing error, so a held break does not retrigger frames.
    assign w_start  = (r_state == c_ST_IDLE) && r_armed && !RX_IN;
    assign w_active = (r_state != c_ST_IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .i_start    (w_start),
        .i_active   (w_active),
        .o_bit_done (w_bit_done),
        .o_bit_val  (w_bit_val)
    );

    // Expected parity bit over the received data word
    always_comb begin
        w_par_exp = ^r_shift;
        case (r_par_typ)
            c_PAR_EVEN: w_par_exp = ^r_shift;
            c_PAR_ODD:  w_par_exp = ~^r_shift;
            default:    w_par_exp = ^r_shift;
        endcase
    end

    // Frame FSM, deserialiser, frame checks and output strobes
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= c_ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b1;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_err  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (!r_armed && RX_IN) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= c_ST_START;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_par_err <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_START: begin
                    if (w_bit_done) begin
                        // A start bit that votes high was a glitch
                        r_state   <= w_bit_val ? c_ST_IDLE : c_ST_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_done) begin
                        r_shift <= {w_bit_val, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= r_par_en ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_done) begin
                        r_par_err <= (w_bit_val != w_par_exp);
                        r_state   <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_done) begin
                        r_state <= c_ST_IDLE;
                        if (r_par_err) begin
                            PAR_ERR <= 1'b1;
                        end else if (!w_bit_val) begin
                            STP_ERR <= 1'b1;
                            r_armed <= 1'b0;
                        end else begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= r_shift;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
